// File: rtl/subtractor_pkg.sv
// Shared constants and payload types for the borrow-select subtractor pipeline.
// Segment split 5/7/9/11 matches the processor carry-select adders.
package subtractor_pkg;

    localparam int W    = 32;
    localparam int SEG0 = 5;
    localparam int SEG1 = 7;
    localparam int SEG2 = 9;
    localparam int SEG3 = 11;

    // Segment base bit positions
    localparam int B1 = SEG0;
    localparam int B2 = SEG0 + SEG1;
    localparam int B3 = SEG0 + SEG1 + SEG2;

    localparam bit SEG_SPLIT_OK = ((SEG0 + SEG1 + SEG2 + SEG3) == W);

    typedef struct packed {
        logic bout;
        logic zero;
        logic neg;
        logic ovf;
    } flags_t;

    typedef struct packed {
        logic [B2-1:0] d;
        logic          br;
        logic [W-1:B2] a;
        logic [W-1:B2] b;
    } s1_t;

    typedef struct packed {
        logic [B3-1:0] d;
        logic          br;
        logic [W-1:B3] a;
        logic [W-1:B3] b;
    } s2_t;

    typedef struct packed {
        logic [W-1:0] d;
        flags_t       f;
    } s3_t;

endpackage

// File: rtl/borrow_select_subtractor_pipe_if.sv
// Operand/result handshake bundle for the subtractor pipeline.
// master = producer/consumer side, slave = the pipeline itself.
interface borrow_select_subtractor_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, zero, neg, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, zero, neg, ovf
    );
endinterface

// File: rtl/fa.sv
// Single-bit full adder cell.
// Purely combinational; no handshake.
module fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/ripple_borrow_seg.sv
// N-bit ripple-borrow subtractor d = a - b - bin built from fa cells on ~b.
// Combinational, zero latency; no handshake.
module ripple_borrow_seg #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] d,
    output logic         bout
);
    // Carry chain is the inverted borrow chain
    logic [N:0] c;

    assign c[0] = ~bin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        fa u_fa (
            .x  (a[i]),
            .y  (~b[i]),
            .ci (c[i]),
            .s  (d[i]),
            .co (c[i+1])
        );
    end

    assign bout = ~c[N];
endmodule

// File: rtl/borrow_select_subtractor_pipe.sv
// 32-bit borrow-select subtractor d = a - b - bin with borrow-out and ALU flags.
// Latency 3 cycles, 1 result/clock; 3-entry valid/ready pipe.
// Backpressure: per-stage ready chain, in_ready combinational from out_ready.
module borrow_select_subtractor_pipe
    import subtractor_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    borrow_select_subtractor_pipe_if.slave  bus
);

    if (!SEG_SPLIT_OK) begin : g_bad_split
        $error("subtractor segment widths must sum to 32");
    end

    logic s1_vld, s2_vld, s3_vld;
    logic s1_rdy, s2_rdy, s3_rdy;
    s1_t  s1_dat, s1_nxt;
    s2_t  s2_dat, s2_nxt;
    s3_t  s3_dat, s3_nxt;

    assign s3_rdy = !s3_vld || bus.out_ready;
    assign s2_rdy = !s2_vld || s3_rdy;
    assign s1_rdy = !s1_vld || s2_rdy;

    // Stage 0 -> S1: seg0 plain ripple, seg1 borrow-select
    logic [SEG0-1:0] seg0_d;
    logic            seg0_bo;
    logic [SEG1-1:0] seg1_d0, seg1_d1;
    logic            seg1_bo0, seg1_bo1;

    ripple_borrow_seg #(.N(SEG0)) u_seg0 (
        .a(bus.a[B1-1:0]), .b(bus.b[B1-1:0]), .bin(bus.bin), .d(seg0_d), .bout(seg0_bo)
    );
    ripple_borrow_seg #(.N(SEG1)) u_seg1_b0 (
        .a(bus.a[B2-1:B1]), .b(bus.b[B2-1:B1]), .bin(1'b0), .d(seg1_d0), .bout(seg1_bo0)
    );
    ripple_borrow_seg #(.N(SEG1)) u_seg1_b1 (
        .a(bus.a[B2-1:B1]), .b(bus.b[B2-1:B1]), .bin(1'b1), .d(seg1_d1), .bout(seg1_bo1)
    );

    assign s1_nxt.d  = {(seg0_bo ? seg1_d1 : seg1_d0), seg0_d};
    assign s1_nxt.br = seg0_bo ? seg1_bo1 : seg1_bo0;
    assign s1_nxt.a  = bus.a[W-1:B2];
    assign s1_nxt.b  = bus.b[W-1:B2];

    // S1 -> S2: seg2 borrow-select
    logic [SEG2-1:0] seg2_d0, seg2_d1;
    logic            seg2_bo0, seg2_bo1;

    ripple_borrow_seg #(.N(SEG2)) u_seg2_b0 (
        .a(s1_dat.a[B3-1:B2]), .b(s1_dat.b[B3-1:B2]), .bin(1'b0), .d(seg2_d0), .bout(seg2_bo0)
    );
    ripple_borrow_seg #(.N(SEG2)) u_seg2_b1 (
        .a(s1_dat.a[B3-1:B2]), .b(s1_dat.b[B3-1:B2]), .bin(1'b1), .d(seg2_d1), .bout(seg2_bo1)
    );

    assign s2_nxt.d  = {(s1_dat.br ? seg2_d1 : seg2_d0), s1_dat.d};
    assign s2_nxt.br = s1_dat.br ? seg2_bo1 : seg2_bo0;
    assign s2_nxt.a  = s1_dat.a[W-1:B3];
    assign s2_nxt.b  = s1_dat.b[W-1:B3];

    // S2 -> S3: seg3 borrow-select and flags
    logic [SEG3-1:0] seg3_d0, seg3_d1;
    logic            seg3_bo0, seg3_bo1;
    logic [W-1:0]    full_d;

    ripple_borrow_seg #(.N(SEG3)) u_seg3_b0 (
        .a(s2_dat.a), .b(s2_dat.b), .bin(1'b0), .d(seg3_d0), .bout(seg3_bo0)
    );
    ripple_borrow_seg #(.N(SEG3)) u_seg3_b1 (
        .a(s2_dat.a), .b(s2_dat.b), .bin(1'b1), .d(seg3_d1), .bout(seg3_bo1)
    );

    assign full_d        = {(s2_dat.br ? seg3_d1 : seg3_d0), s2_dat.d};
    assign s3_nxt.d      = full_d;
    assign s3_nxt.f.bout = s2_dat.br ? seg3_bo1 : seg3_bo0;
    assign s3_nxt.f.zero = (full_d == '0);
    assign s3_nxt.f.neg  = full_d[W-1];
    assign s3_nxt.f.ovf  = (s2_dat.a[W-1] != s2_dat.b[W-1]) && (full_d[W-1] != s2_dat.a[W-1]);

    // Payloads only load behind a valid so idle inputs never reach the registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s3_vld <= 1'b0;
            s1_dat <= '0;
            s2_dat <= '0;
            s3_dat <= '0;
        end else begin
            if (s1_rdy) begin
                s1_vld <= bus.in_valid;
                if (bus.in_valid) s1_dat <= s1_nxt;
            end
            if (s2_rdy) begin
                s2_vld <= s1_vld;
                if (s1_vld) s2_dat <= s2_nxt;
            end
            if (s3_rdy) begin
                s3_vld <= s2_vld;
                if (s2_vld) s3_dat <= s3_nxt;
            end
        end
    end

    assign bus.in_ready  = s1_rdy;
    assign bus.out_valid = s3_vld;
    assign bus.d         = s3_dat.d;
    assign bus.bout      = s3_dat.f.bout;
    assign bus.zero      = s3_dat.f.zero;
    assign bus.neg       = s3_dat.f.neg;
    assign bus.ovf       = s3_dat.f.ovf;

endmodule

// File: tb/tb_borrow_select_subtractor_pipe.sv
// Directed and random checks of the 3-stage borrow-select subtractor pipeline.
module tb_borrow_select_subtractor_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    borrow_select_subtractor_pipe_if bus ();

    borrow_select_subtractor_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0]  ta [4];
    logic [31:0]  td [4];
    logic [35:0]  sb [$];
    logic [35:0]  exp_v;
    int           idx;
    int           n_in;
    int           n_out;
    int           cyc;
    logic         acc;
    logic         fired_in;
    logic         any_vld;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] t;
        logic [31:0] dd;
        t  = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        dd = t[31:0];
        return {dd, t[32], (dd == 32'd0), dd[31], (a[31] != b[31]) && (dd[31] != a[31])};
    endfunction

    function automatic logic [35:0] observed();
        return {bus.d, bus.bout, bus.zero, bus.neg, bus.ovf};
    endfunction

    // Drive one op into an empty pipe, check latency and all result fields
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic bin, input logic [31:0] exp_d, input logic [3:0] exp_f);
        int  lat;
        logic seen;
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            else begin
                lat++;
                @(posedge clk); #1;
            end
        end
        chk({tag, ".latency"}, lat, 2);
        chk({tag, ".result"}, observed(), {exp_d, exp_f});
        @(posedge clk); #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.out_valid", bus.out_valid, 0);
        chk("reset.result", observed(), 36'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic, wrap, signed overflow
        run_op("t1", 32'd5, 32'd3, 1'b0, 32'h00000002, 4'b0000);
        run_op("t2a", 32'd0, 32'd1, 1'b0, 32'hFFFFFFFF, 4'b1010);
        run_op("t2b", 32'h80000000, 32'd1, 1'b0, 32'h7FFFFFFF, 4'b0001);

        // Borrow across each segment boundary
        run_op("t3_b5", 32'h00000020, 32'd1, 1'b0, 32'h0000001F, 4'b0000);
        run_op("t3_b12", 32'h00001000, 32'd1, 1'b0, 32'h00000FFF, 4'b0000);
        run_op("t3_b21", 32'h00200000, 32'd1, 1'b0, 32'h001FFFFF, 4'b0000);

        // Equal operands, with and without borrow-in
        run_op("t4_eq", 32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 4'b0100);
        run_op("t4_eqb", 32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 4'b1010);

        // Fill under stall: only 3 accepted
        ta = '{32'h00000010, 32'h00000100, 32'h00001000, 32'h00010000};
        td = '{32'h0000000F, 32'h000000FF, 32'h00000FFF, 32'h0000FFFF};
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            bus.a        = ta[idx];
            bus.b        = 32'd1;
            bus.bin      = 1'b0;
            bus.in_valid = 1'b1;
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc && idx < 3) idx++;
        end
        @(negedge clk);
        chk("t5.accepted", idx, 3);
        chk("t5.in_ready_full", bus.in_ready, 0);
        chk("t5.out_valid_stall", bus.out_valid, 1);
        chk("t5.d_stall0", bus.d, td[0]);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5.d_stall1", bus.d, td[0]);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) chk("t5.in_ready_drain", bus.in_ready, 1);
            chk($sformatf("t5.out_valid%0d", k), bus.out_valid, 1);
            chk($sformatf("t5.d%0d", k), bus.d, td[k]);
            @(posedge clk); #1;
            if (k == 0) bus.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("t5.drained", bus.out_valid, 0);
        @(posedge clk); #1;

        // Reset with two entries in flight and an accept attempted during reset
        bus.out_ready = 1'b1;
        bus.a = 32'd7; bus.b = 32'd2; bus.bin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 32'd9; bus.b = 32'd4;
        @(posedge clk); #1;
        rst   = 1'b1;
        bus.a = 32'd100; bus.b = 32'd1;
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6.out_valid", bus.out_valid, 0);
        chk("t6.result", observed(), 36'd0);
        any_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            any_vld = any_vld | bus.out_valid;
        end
        chk("t6.no_stale", any_vld, 0);
        @(posedge clk); #1;
        run_op("t6_post", 32'h00000011, 32'h00000022, 1'b1, 32'hFFFFFFEE, 4'b1010);

        // Random scoreboard
        n_in     = 0;
        n_out    = 0;
        cyc      = 0;
        fired_in = 1'b0;
        bus.in_valid = 1'b0;
        while (n_out < 10000 && cyc < 60000) begin
            if (!bus.in_valid || fired_in) begin
                if (n_in < 10000 && $urandom_range(3) != 0) begin
                    bus.a   = $urandom;
                    bus.b   = ($urandom_range(7) == 0) ? bus.a : $urandom;
                    bus.bin = $urandom_range(1);
                    bus.in_valid = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            fired_in = bus.in_valid && bus.in_ready;
            if (fired_in) begin
                sb.push_back(model(bus.a, bus.b, bus.bin));
                n_in++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("rand.unexpected_output", 1, 0);
                end else begin
                    exp_v = sb.pop_front();
                    chk("rand.result", observed(), exp_v);
                end
                n_out++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("rand.completed", n_out, 10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
